// File: rtl/hazard_fwd_scoreboard.sv
// Hazard and forwarding scoreboard: shadows in-flight destinations from EX onward and produces
// load-use / multi-cycle stall control plus registered EX operand forward selects.
module hazard_fwd_scoreboard #(
    parameter int unsigned NUM_SRC    = 2,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned FWD_DEPTH  = 2,
    parameter int unsigned LOAD_LAT   = 1,
    parameter int unsigned MC_LAT     = 4,
    localparam int unsigned SEL_W     = $clog2(FWD_DEPTH + 1)
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          id_valid,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] id_rs,
    input  logic [NUM_SRC-1:0]            id_use_rs,
    input  logic [REG_ADDR_W-1:0]         id_rd,
    input  logic                          id_regwrite,
    input  logic                          id_is_load,
    input  logic                          id_is_mc,
    input  logic                          flush,
    output logic                          stall,
    output logic                          ex_bubble,
    output logic                          ex_hold,
    output logic                          ex_first,
    output logic [NUM_SRC*SEL_W-1:0]      fwd_sel_ex
);

    localparam int unsigned CNT_W = $clog2(MC_LAT + 1);

    // A load's data is usable from slot 1+LOAD_LAT; everything else from slot 1.
    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  regwrite;
        logic                  is_load;
    } slot_t;

    slot_t                     slot_q [FWD_DEPTH+1];
    slot_t                     slot_d [FWD_DEPTH+1];
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      first_q, first_d;
    logic [NUM_SRC*SEL_W-1:0]  sel_q, sel_d;
    logic [NUM_SRC*SEL_W-1:0]  sel_match;
    logic [NUM_SRC-1:0]        src_haz;
    logic [REG_ADDR_W-1:0]     rs [NUM_SRC];
    logic                      hazard;
    logic                      issue;

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_rs
        assign rs[s] = id_rs[s*REG_ADDR_W +: REG_ADDR_W];
    end

    // Scan oldest to youngest so the youngest match overwrites; the last slot never forwards.
    always_comb begin
        sel_match = '0;
        src_haz   = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            if (id_use_rs[s] && rs[s] != '0) begin
                for (int j = int'(FWD_DEPTH) - 1; j >= 0; j--) begin
                    if (slot_q[j].valid && slot_q[j].regwrite && slot_q[j].rd == rs[s]) begin
                        sel_match[s*SEL_W +: SEL_W] = SEL_W'(j + 1);
                        src_haz[s] = slot_q[j].is_load && (j < int'(LOAD_LAT));
                    end
                end
            end
        end
    end

    assign ex_hold    = (cnt_q != '0);
    assign hazard     = (|src_haz) | ex_hold;
    assign issue      = id_valid & ~hazard & ~flush;
    assign stall      = (id_valid & hazard & ~flush) | ex_hold;
    assign ex_bubble  = id_valid & hazard & ~flush & ~ex_hold;
    assign ex_first   = first_q;
    assign fwd_sel_ex = sel_q;

    always_comb begin
        slot_d  = slot_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        first_d = 1'b0;
        for (int k = 2; k <= int'(FWD_DEPTH); k++) begin
            slot_d[k] = slot_q[k-1];
        end
        if (ex_hold) begin
            // EX frozen: a bubble trails the busy op into the post-EX stages.
            slot_d[1] = '0;
            cnt_d     = cnt_q - 1'b1;
        end else begin
            slot_d[1] = slot_q[0];
            slot_d[0] = '0;
            if (issue) begin
                slot_d[0].valid    = 1'b1;
                slot_d[0].rd       = id_rd;
                slot_d[0].regwrite = id_regwrite;
                slot_d[0].is_load  = id_is_load;
            end
            sel_d   = sel_match;
            first_d = issue;
            cnt_d   = (issue && id_is_mc) ? CNT_W'(MC_LAT - 1) : '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k <= int'(FWD_DEPTH); k++) begin
                slot_q[k] <= '0;
            end
            cnt_q   <= '0;
            first_q <= 1'b0;
            sel_q   <= '0;
        end else begin
            slot_q  <= slot_d;
            cnt_q   <= cnt_d;
            first_q <= first_d;
            sel_q   <= sel_d;
        end
    end

endmodule

// File: tb/tb_hazard_fwd_scoreboard.sv
// Bench for hazard_fwd_scoreboard: directed scenarios then random traffic, all checked against an
// instruction-level model of the pipeline (EX occupant, busy cycles left, post-EX history).
module tb_hazard_fwd_scoreboard;

    localparam int NS  = 2;
    localparam int AW  = 5;
    localparam int FD  = 2;
    localparam int LL  = 1;
    localparam int MCL = 4;
    localparam int SW  = $clog2(FD + 1);

    logic              clk = 1'b0;
    logic              reset_n;
    logic              id_valid;
    logic [NS*AW-1:0]  id_rs;
    logic [NS-1:0]     id_use_rs;
    logic [AW-1:0]     id_rd;
    logic              id_regwrite;
    logic              id_is_load;
    logic              id_is_mc;
    logic              flush;
    logic              stall;
    logic              ex_bubble;
    logic              ex_hold;
    logic              ex_first;
    logic [NS*SW-1:0]  fwd_sel_ex;

    hazard_fwd_scoreboard #(
        .NUM_SRC    (NS),
        .REG_ADDR_W (AW),
        .FWD_DEPTH  (FD),
        .LOAD_LAT   (LL),
        .MC_LAT     (MCL)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_use_rs   (id_use_rs),
        .id_rd       (id_rd),
        .id_regwrite (id_regwrite),
        .id_is_load  (id_is_load),
        .id_is_mc    (id_is_mc),
        .flush       (flush),
        .stall       (stall),
        .ex_bubble   (ex_bubble),
        .ex_hold     (ex_hold),
        .ex_first    (ex_first),
        .fwd_sel_ex  (fwd_sel_ex)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       valid;
        bit [4:0] rd;
        bit       rw;
        bit       ld;
    } rec_t;

    int          n_total = 0;
    int          n_pass  = 0;
    int          n_fail  = 0;

    rec_t        ex_rec;
    rec_t        post[$];
    int          mc_left;
    bit [NS*SW-1:0] m_sel;
    bit [NS*SW-1:0] m_next_sel;
    bit          m_first;
    bit          m_haz;
    bit          last_stall, last_bubble, last_hold, last_flush;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic rec_t bubble_rec();
        rec_t r;
        r.valid = 0; r.rd = 0; r.rw = 0; r.ld = 0;
        return r;
    endfunction

    function automatic void model_reset();
        ex_rec = bubble_rec();
        post.delete();
        for (int i = 0; i < FD; i++) post.push_back(bubble_rec());
        mc_left = 0;
        m_sel   = '0;
        m_first = 0;
    endfunction

    // Producer at distance d (1 = in EX) forwards from slot d; a load is ready only at d >= 1+LL.
    function automatic void model_eval();
        m_haz      = (mc_left > 0);
        m_next_sel = '0;
        for (int s = 0; s < NS; s++) begin
            bit [4:0] r;
            r = id_rs[s*AW +: AW];
            if (id_use_rs[s] && r != 0) begin
                for (int d = 1; d <= FD; d++) begin
                    rec_t p;
                    p = (d == 1) ? ex_rec : post[d-2];
                    if (p.valid && p.rw && p.rd == r) begin
                        m_next_sel[s*SW +: SW] = SW'(d);
                        if (p.ld && d < 1 + LL) m_haz = 1;
                        break;
                    end
                end
            end
        end
    endfunction

    function automatic void model_edge();
        bit issue;
        if (mc_left > 0) begin
            post.push_front(bubble_rec());
            mc_left--;
            m_first = 0;
        end else begin
            post.push_front(ex_rec);
            issue = id_valid && !m_haz && !flush;
            ex_rec = bubble_rec();
            if (issue) begin
                ex_rec.valid = 1; ex_rec.rd = id_rd; ex_rec.rw = id_regwrite; ex_rec.ld = id_is_load;
            end
            m_sel   = m_next_sel;
            m_first = issue;
            mc_left = (issue && id_is_mc) ? MCL - 1 : 0;
        end
        void'(post.pop_back());
    endfunction

    task automatic drive_idle();
        id_valid = 0; id_rs = '0; id_use_rs = '0; id_rd = '0;
        id_regwrite = 0; id_is_load = 0; id_is_mc = 0; flush = 0;
    endtask

    task automatic step(input bit v, input bit [4:0] r0, input bit [4:0] r1, input bit [1:0] u,
                        input bit [4:0] rd, input bit rw, input bit ld, input bit mc, input bit fl);
        bit exp_hold, exp_stall, exp_bub;
        @(negedge clk);
        id_valid = v; id_rs = {r1, r0}; id_use_rs = u; id_rd = rd;
        id_regwrite = rw; id_is_load = ld; id_is_mc = mc; flush = fl;
        #1;
        model_eval();
        exp_hold  = (mc_left > 0);
        exp_stall = (v && m_haz && !fl) || exp_hold;
        exp_bub   = v && m_haz && !fl && !exp_hold;
        chk("stall", stall, exp_stall);
        chk("ex_bubble", ex_bubble, exp_bub);
        chk("ex_hold", ex_hold, exp_hold);
        chk("ex_first", ex_first, m_first);
        chk("fwd_sel_ex", fwd_sel_ex, m_sel);
        last_stall  = stall;
        last_bubble = ex_bubble;
        last_hold   = ex_hold;
        last_flush  = fl;
        @(posedge clk);
        model_edge();
    endtask

    initial begin
        int n_stall, n_hold;
        bit cv, cld, cmc, crw, cfl;
        bit [4:0] c0, c1, crd;
        bit [1:0] cu;

        // Reset with a self-matching instruction in ID: nothing is in flight, so all quiet.
        reset_n = 0;
        id_valid = 1; id_rs = {5'd5, 5'd5}; id_use_rs = 2'b11; id_rd = 5'd5;
        id_regwrite = 1; id_is_load = 1; id_is_mc = 0; flush = 0;
        repeat (2) @(negedge clk);
        chk("rst_stall", stall, 0);
        chk("rst_bubble", ex_bubble, 0);
        chk("rst_sel", fwd_sel_ex, 0);
        chk("rst_hold", ex_hold, 0);
        chk("rst_first", ex_first, 0);
        model_reset();
        drive_idle();
        reset_n = 1;

        // ALU back-to-back forwarding.
        step(1, 1, 2, 3, 5, 1, 0, 0, 0);
        step(1, 5, 3, 3, 6, 1, 0, 0, 0);
        chk("alu_no_stall", last_stall, 0);
        #1 chk("alu_b2b_sel0", fwd_sel_ex[1:0], 1);
        step(1, 4, 5, 3, 8, 1, 0, 0, 0);
        #1 chk("alu_dist2_sel1", fwd_sel_ex[3:2], 2);

        // Load-use: one stall/bubble cycle, then forward from slot 2.
        step(1, 1, 1, 3, 7, 1, 1, 0, 0);
        step(1, 2, 7, 3, 10, 1, 0, 0, 0);
        chk("lu_stall", last_stall, 1);
        chk("lu_bubble", last_bubble, 1);
        step(1, 2, 7, 3, 10, 1, 0, 0, 0);
        chk("lu_release", last_stall, 0);
        #1 chk("lu_sel1", fwd_sel_ex[3:2], 2);

        // x0 destination and unused source never create hazards.
        step(1, 1, 1, 3, 0, 1, 1, 0, 0);
        step(1, 0, 0, 3, 11, 1, 0, 0, 0);
        chk("x0_no_stall", last_stall, 0);
        #1 chk("x0_sel", fwd_sel_ex, 0);
        step(1, 1, 1, 3, 7, 1, 1, 0, 0);
        step(1, 2, 7, 2'b01, 12, 1, 0, 0, 0);
        chk("unused_no_stall", last_stall, 0);
        #1 chk("unused_sel", fwd_sel_ex, 0);

        // Multi-cycle op: three held cycles, consumer then forwards from slot 1.
        step(1, 1, 2, 3, 9, 1, 0, 1, 0);
        #1 chk("mc_first", ex_first, 1);
        n_stall = 0;
        n_hold  = 0;
        for (int i = 0; i < 10; i++) begin
            step(1, 9, 0, 2'b01, 13, 1, 0, 0, 0);
            if (last_hold) n_hold++;
            if (!last_stall) break;
            n_stall++;
        end
        chk("mc_stall_cycles", n_stall, 3);
        chk("mc_hold_cycles", n_hold, 3);
        #1 chk("mc_sel0", fwd_sel_ex[1:0], 1);

        // Flush in the load-use stall cycle kills the consumer.
        step(1, 1, 1, 3, 7, 1, 1, 0, 0);
        step(1, 7, 2, 3, 14, 1, 0, 0, 1);
        chk("flush_stall", last_stall, 0);
        chk("flush_bubble", last_bubble, 0);
        #1 chk("flush_first", ex_first, 0);
        step(1, 14, 14, 3, 15, 1, 0, 0, 0);
        chk("flush_killed_rd", last_stall, 0);
        #1 chk("flush_killed_sel", fwd_sel_ex, 0);

        // Reset during a hold leaves no pending hold.
        step(1, 1, 2, 3, 9, 1, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2 reset_n = 0;
        #1 chk("midrst_hold", ex_hold, 0);
        chk("midrst_stall", stall, 0);
        model_reset();
        drive_idle();
        @(negedge clk) reset_n = 1;
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Random traffic; a stalled ID instruction is held stable unless flushed.
        cv = 0; c0 = 0; c1 = 0; cu = 0; crd = 0; crw = 0; cld = 0; cmc = 0;
        for (int i = 0; i < 3000; i++) begin
            if (!(last_stall && !last_flush && cv)) begin
                cv  = ($urandom_range(9) != 0);
                c0  = 5'($urandom_range(3));
                c1  = 5'($urandom_range(3));
                cu  = 2'($urandom_range(3));
                crd = 5'($urandom_range(3));
                crw = ($urandom_range(5) != 0);
                cld = ($urandom_range(3) == 0);
                cmc = !cld && ($urandom_range(7) == 0);
            end
            cfl = ($urandom_range(7) == 0);
            step(cv, c0, c1, cu, crd, crw, cld, cmc, cfl);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
